// File: rtl/fsm_vend_param_pkg.sv
// Shared types and constants for the parametrised vending controller.
package fsm_vend_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  // coin weights in half-units
  localparam int W_A = 1;
  localparam int W_B = 2;

endpackage

// File: rtl/fsm_vend_param_if.sv
// Coin/hopper/flag bundle between the vending controller and its surroundings.
interface fsm_vend_param_if #(
  parameter int CW = 4
);
  logic          a_point5;
  logic          b_1;
  logic          cancel;
  logic          chg_ready;
  logic          coin_ready;
  logic          sell_flag;
  logic          refund_flag;
  logic          chg_valid;
  logic [CW-1:0] credit;

  modport master (
    output a_point5, b_1, cancel, chg_ready,
    input  coin_ready, sell_flag, refund_flag, chg_valid, credit
  );

  modport slave (
    input  a_point5, b_1, cancel, chg_ready,
    output coin_ready, sell_flag, refund_flag, chg_valid, credit
  );
endinterface

// File: rtl/fsm_vend_param_change.sv
// Loadable down-counter paying out one half-unit per valid/ready beat.
module fsm_vend_param_change #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          ready,
  output logic          valid,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (valid && ready) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign valid = (cnt != '0);
  // last half-unit is being accepted on this edge
  assign done  = valid && ready && (cnt == CW'(1));

endmodule

// File: rtl/fsm_vend_param.sv
// Vending controller: credit accumulation, vend, change/refund payout.
// Optional idle auto-refund is built when FSM_VEND_TIMEOUT_EN is defined.
module fsm_vend_param
  import fsm_vend_param_pkg::*;
#(
  parameter int PRICE   = 3,
  parameter int CW      = 4,
  parameter int TMO_CYC = 50
) (
  input logic             clk,
  input logic             rst,
  fsm_vend_param_if.slave bus
);

  if (PRICE < 1 || PRICE > (2**CW) - 3) begin : g_bad_price
    $error("PRICE out of range for CW");
  end
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("TMO_CYC must be at least 1");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] credit_q, credit_nxt;
  logic [CW-1:0] add, sum, load_val;
  logic          load, coin, timeout;
  logic          refund_q, refund_nxt;
  logic          chg_valid_i, chg_done, chg_ready_i;

  assign add  = (bus.a_point5 ? CW'(W_A) : '0) + (bus.b_1 ? CW'(W_B) : '0);
  assign sum  = credit_q + add;
  assign coin = bus.a_point5 || bus.b_1;

`ifdef FSM_VEND_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_q;

  // counts coin-less COLLECT cycles down to terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= TW'(TMO_CYC - 1);
    end else if (state != ST_COLLECT || coin) begin
      tmo_q <= TW'(TMO_CYC - 1);
    end else if (tmo_q != '0) begin
      tmo_q <= tmo_q - 1'b1;
    end
  end

  assign timeout = (state == ST_COLLECT) && !coin && (tmo_q == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      credit_q <= '0;
      refund_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      refund_q <= refund_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit_q;
    load       = 1'b0;
    load_val   = sum - CW'(PRICE);
    refund_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_COLLECT: begin
        // a coin always wins over a simultaneous cancel
        if (coin) begin
          if (sum >= CW'(PRICE)) begin
            state_nxt  = ST_VEND;
            credit_nxt = '0;
            load       = 1'b1;
          end else begin
            state_nxt  = ST_COLLECT;
            credit_nxt = sum;
          end
        end else if (state == ST_COLLECT && (bus.cancel || timeout)) begin
          state_nxt  = ST_CHANGE;
          credit_nxt = '0;
          load       = 1'b1;
          load_val   = credit_q;
          refund_nxt = 1'b1;
        end
      end
      ST_VEND: begin
        state_nxt = chg_valid_i ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (chg_done || !chg_valid_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.coin_ready  = (state == ST_IDLE) || (state == ST_COLLECT);
    bus.sell_flag   = (state == ST_VEND);
    bus.refund_flag = refund_q;
    bus.chg_valid   = (state == ST_CHANGE) && chg_valid_i;
    bus.credit      = credit_q;
    chg_ready_i     = (state == ST_CHANGE) && bus.chg_ready;
  end

  fsm_vend_param_change #(.CW(CW)) u_change (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .ready    (chg_ready_i),
    .valid    (chg_valid_i),
    .done     (chg_done)
  );

endmodule
